// File: rtl/enc_round_stage.sv
// AES-128 encryption round stage with a valid/ready handshake.
//
// Each beat carries its own in_last flag:
//   in_last = 0 : full round  -> SubBytes, ShiftRows, MixColumns, AddRoundKey
//   in_last = 1 : final round -> SubBytes, ShiftRows, AddRoundKey
//
// The pipeline has two stages:
//   S1 registers SubBytes(in_data), the round key, the last flag, the id and a valid bit.
//   ShiftRows, the optional MixColumns and the key XOR are combinational after S1.
//   OUT_REG=1 adds an output register (S2). OUT_REG=0 drives out_* straight from the S1 round logic.
//
// Parameters:
//   OUT_REG   1 = registered output stage, 0 = combinational output after S1
//   ID_W      width of the sideband tag
//
// Ports:
//   clk, rst_n           clock and asynchronous active-low reset
//   in_valid/in_ready    input handshake; in_ready has no path from in_valid
//   in_last              final-round select for this beat
//   in_rkey, in_data     round key and state; bits 127:120 hold state byte 0, column-major
//   in_id                tag returned unchanged on out_id
//   out_valid/out_ready  output handshake
//   out_data, out_id     round result and its tag
//   inflight             number of beats currently held (0 .. 1+OUT_REG)

// Single AES S-box lookup.
// It computes the multiplicative inverse in GF(2^8) as x^254 and then applies the affine map.
module sub_bytes (
  input  logic [7:0] value,
  output logic [7:0] result
);

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = 8'h00;
    x   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = xtime(x);
    end
    return acc;
  endfunction

  // x^254 = x^2 * x^4 * ... * x^128.
  // An input of 0 maps to 0, which is the inverse convention the S-box uses.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] pw;
    logic [7:0] inv;
    pw  = a;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      pw  = gf_mul(pw, pw);
      inv = gf_mul(inv, pw);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  assign result = sbox(value);

endmodule

module enc_round_stage #(
  parameter int OUT_REG = 1,
  parameter int ID_W    = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_last,
  input  logic [127:0]    in_rkey,
  input  logic [127:0]    in_data,
  input  logic [ID_W-1:0] in_id,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [127:0]    out_data,
  output logic [ID_W-1:0] out_id,
  output logic [1:0]      inflight
);

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Row r of column c lives at byte index r + 4*c.
  // Row r rotates left by r columns.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] t;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        t[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
      end
    end
    return t;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] t;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      t[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      t[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      t[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      t[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return t;
  endfunction

  logic [127:0]    sb_p0;
  logic            en_p1;
  logic            en_p2;
  logic            vld_p1;
  logic            vld_p2;
  logic            last_p1;
  logic [127:0]    data_p1;
  logic [127:0]    rkey_p1;
  logic [ID_W-1:0] id_p1;
  logic [127:0]    sr_p1;
  logic [127:0]    rnd_p1;

  // ---- p0: SubBytes on the incoming state ----
  for (genvar i = 0; i < 16; i++) begin : g_sbox
    sub_bytes u_sbox (
      .value  (in_data[127-8*i -: 8]),
      .result (sb_p0[127-8*i -: 8])
    );
  end

  // A stage may load when it is empty or when its contents leave this cycle.
  assign en_p1    = !vld_p1 || en_p2;
  assign in_ready = en_p1;

  // ---- p1: registered S-box output, key, last flag and tag ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
      data_p1 <= '0;
      rkey_p1 <= '0;
      id_p1   <= '0;
    end else if (en_p1) begin
      vld_p1 <= in_valid;
      if (in_valid) begin
        last_p1 <= in_last;
        data_p1 <= sb_p0;
        rkey_p1 <= in_rkey;
        id_p1   <= in_id;
      end
    end
  end

  assign sr_p1  = shift_rows(data_p1);
  assign rnd_p1 = (last_p1 ? sr_p1 : mix_columns(sr_p1)) ^ rkey_p1;

  // ---- p2: optional output register ----
  if (OUT_REG != 0) begin : g_out_reg
    logic [127:0]    data_p2;
    logic [ID_W-1:0] id_p2;

    assign en_p2 = !vld_p2 || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_p2  <= 1'b0;
        data_p2 <= '0;
        id_p2   <= '0;
      end else if (en_p2) begin
        vld_p2 <= vld_p1;
        if (vld_p1) begin
          data_p2 <= rnd_p1;
          id_p2   <= id_p1;
        end
      end
    end

    assign out_valid = vld_p2;
    assign out_data  = data_p2;
    assign out_id    = id_p2;
  end else begin : g_out_comb
    assign en_p2     = out_ready;
    assign vld_p2    = 1'b0;
    assign out_valid = vld_p1;
    assign out_data  = rnd_p1;
    assign out_id    = id_p1;
  end

  // The beat count is a sum of registered valid bits only.
  assign inflight = {1'b0, vld_p1} + {1'b0, vld_p2};

endmodule

// File: tb/tb_enc_round_stage.sv
// Testbench for enc_round_stage.
// dut1 uses OUT_REG=1 and is checked by a scoreboard plus directed steps.
// dut0 uses OUT_REG=0 and is checked by directed steps.
`timescale 1ns/1ps

`define CHK(tag, obs, exp) begin n_assert++; assert ((obs) === (exp)) else begin n_fail++; $error("FAIL %s: observed=%0h expected=%0h", tag, (obs), (exp)); end end

module tb_enc_round_stage;
  localparam int ID_W = 4;

  localparam logic [127:0] R10_IN  = 128'heb40f21e592e38848ba113e71bc342d2;
  localparam logic [127:0] R10_KEY = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] R10_OUT = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] R1_IN   = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] R1_KEY  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] R1_OUT  = 128'ha49c7ff2689f352b6b5bea43026a5049;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic            in_valid, in_ready, in_last, out_valid, out_ready;
  logic [127:0]    in_rkey, in_data, out_data;
  logic [ID_W-1:0] in_id, out_id;
  logic [1:0]      inflight;

  logic            in_valid0, in_ready0, out_valid0, out_ready0;
  logic [127:0]    out_data0;
  logic [ID_W-1:0] out_id0;
  logic [1:0]      inflight0;

  enc_round_stage #(.OUT_REG(1), .ID_W(ID_W)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .in_rkey(in_rkey), .in_data(in_data), .in_id(in_id),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_id(out_id), .inflight(inflight)
  );

  enc_round_stage #(.OUT_REG(0), .ID_W(ID_W)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0),
    .in_last(in_last), .in_rkey(in_rkey), .in_data(in_data), .in_id(in_id),
    .out_valid(out_valid0), .out_ready(out_ready0), .out_data(out_data0),
    .out_id(out_id0), .inflight(inflight0)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // ---------------- reference model ----------------
  logic [7:0] sbt [256];

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // S-box table from log/antilog tables over generator 3.
  task automatic build_sbox();
    logic [7:0] ex [255];
    int         lg [256];
    logic [7:0] x, inv, s, r;
    x = 8'h01;
    for (int i = 0; i < 255; i++) begin
      ex[i] = x;
      lg[x] = i;
      x = x ^ xt(x);
    end
    for (int a = 0; a < 256; a++) begin
      inv = (a == 0) ? 8'h00 : ex[(255 - lg[a]) % 255];
      s = inv ^ 8'h63;
      r = inv;
      for (int k = 0; k < 4; k++) begin
        r = {r[6:0], r[7]};
        s = s ^ r;
      end
      sbt[a] = s;
    end
  endtask

  function automatic logic [7:0] mulc(input int c, input logic [7:0] x);
    if (c == 2) return xt(x);
    if (c == 3) return xt(x) ^ x;
    return x;
  endfunction

  function automatic logic [127:0] model_round(input logic [127:0] st, input logic [127:0] key,
                                               input logic last);
    logic [7:0]   s [4][4];
    logic [7:0]   t [4][4];
    logic [7:0]   m;
    logic [127:0] res;
    int           coef [4];
    coef = '{2, 3, 1, 1};
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        s[r][c] = sbt[st[127-8*(r+4*c) -: 8]];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        t[r][c] = s[r][(c+r)%4];
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        for (int r = 0; r < 4; r++) begin
          m = 8'h00;
          for (int k = 0; k < 4; k++) m = m ^ mulc(coef[(k-r+4)%4], t[k][c]);
          s[r][c] = m;
        end
      end
      t = s;
    end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        res[127-8*(r+4*c) -: 8] = t[r][c];
    return res ^ key;
  endfunction

  // ---------------- scoreboard monitor for dut1 ----------------
  typedef struct packed {
    logic [127:0]    data;
    logic [ID_W-1:0] id;
  } exp_t;

  exp_t            q[$];
  exp_t            e_mon;
  int              acc_cnt = 0;
  int              emit_cnt = 0;
  logic            hold_prev = 1'b0;
  logic [127:0]    hold_data;
  logic [ID_W-1:0] hold_id;
  logic [1:0]      exp_cnt;

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      acc_cnt   = 0;
      emit_cnt  = 0;
      hold_prev = 1'b0;
    end else begin
      exp_cnt = 2'(acc_cnt - emit_cnt);
      n_assert++;
      if (inflight !== exp_cnt) begin
        n_fail++;
        $error("FAIL inflight_count: observed=%0h expected=%0h", inflight, exp_cnt);
      end
      if (hold_prev) begin
        n_assert++;
        if (out_valid !== 1'b1) begin
          n_fail++;
          $error("FAIL hold_valid: observed=%0h expected=1", out_valid);
        end
        n_assert++;
        if (out_data !== hold_data) begin
          n_fail++;
          $error("FAIL hold_data: observed=%0h expected=%0h", out_data, hold_data);
        end
        n_assert++;
        if (out_id !== hold_id) begin
          n_fail++;
          $error("FAIL hold_id: observed=%0h expected=%0h", out_id, hold_id);
        end
      end
      if (in_valid && in_ready) begin
        e_mon.data = model_round(in_data, in_rkey, in_last);
        e_mon.id   = in_id;
        q.push_back(e_mon);
        acc_cnt++;
      end
      if (out_valid && out_ready) begin
        n_assert++;
        if (q.size() == 0) begin
          n_fail++;
          $error("FAIL sb_nonempty: output with empty scoreboard");
        end else begin
          e_mon = q.pop_front();
          n_assert++;
          if (out_data !== e_mon.data) begin
            n_fail++;
            $error("FAIL sb_data: observed=%0h expected=%0h", out_data, e_mon.data);
          end
          n_assert++;
          if (out_id !== e_mon.id) begin
            n_fail++;
            $error("FAIL sb_id: observed=%0h expected=%0h", out_id, e_mon.id);
          end
        end
        emit_cnt++;
      end
      hold_prev = out_valid && !out_ready;
      hold_data = out_data;
      hold_id   = out_id;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_rand(input int idv);
    in_data = {$urandom(), $urandom(), $urandom(), $urandom()};
    in_rkey = {$urandom(), $urandom(), $urandom(), $urandom()};
    in_last = 1'($urandom_range(0, 1));
    in_id   = ID_W'(idv);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while ((q.size() != 0 || out_valid) && n < 20) begin
      tick();
      n++;
    end
    `CHK(tag, q.size(), 0)
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   nb, sent, cyc;
    logic acc;

    build_sbox();
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b1; in_valid0 = 1'b0; out_ready0 = 1'b1;
    in_last = 1'b0; in_rkey = '0; in_data = '0; in_id = '0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    `CHK("rst_out_valid", out_valid, 1'b0)
    `CHK("rst_out_data", out_data, 128'h0)
    `CHK("rst_out_id", out_id, 4'h0)
    `CHK("rst_inflight", inflight, 2'd0)
    `CHK("rst_out_valid0", out_valid0, 1'b0)
    `CHK("rst_out_data0", out_data0, 128'h0)
    `CHK("rst_inflight0", inflight0, 2'd0)
    rst_n = 1'b1;
    #1;
    `CHK("rst_in_ready", in_ready, 1'b1)
    `CHK("rst_in_ready0", in_ready0, 1'b1)

    // Final round, OUT_REG=1: result exactly two cycles after accept.
    tick();
    in_valid = 1'b1; in_last = 1'b1; in_data = R10_IN; in_rkey = R10_KEY; in_id = 4'd5;
    tick();
    in_valid = 1'b0;
    `CHK("r10_not_early", out_valid, 1'b0)
    tick();
    `CHK("r10_valid", out_valid, 1'b1)
    `CHK("r10_data", out_data, R10_OUT)
    `CHK("r10_id", out_id, 4'd5)
    tick();

    // Full round, OUT_REG=0: result one cycle after accept.
    in_valid0 = 1'b1; in_last = 1'b0; in_data = R1_IN; in_rkey = R1_KEY; in_id = 4'd9;
    tick();
    in_valid0 = 1'b0;
    `CHK("r1_valid0", out_valid0, 1'b1)
    `CHK("r1_data0", out_data0, R1_OUT)
    `CHK("r1_id0", out_id0, 4'd9)
    tick();
    `CHK("r1_gone0", out_valid0, 1'b0)

    // OUT_REG=0 is full with a single beat and holds it under backpressure.
    out_ready0 = 1'b0;
    in_valid0 = 1'b1; in_last = 1'b1; in_data = R10_IN; in_rkey = R10_KEY; in_id = 4'd3;
    tick();
    in_valid0 = 1'b0;
    `CHK("bp0_valid", out_valid0, 1'b1)
    `CHK("bp0_in_ready", in_ready0, 1'b0)
    `CHK("bp0_inflight", inflight0, 2'd1)
    tick();
    tick();
    `CHK("bp0_hold_data", out_data0, R10_OUT)
    `CHK("bp0_hold_id", out_id0, 4'd3)
    out_ready0 = 1'b1;
    #1;
    `CHK("bp0_ready_rise", in_ready0, 1'b1)
    tick();
    `CHK("bp0_drained", out_valid0, 1'b0)
    `CHK("bp0_inflight_end", inflight0, 2'd0)

    // Streaming: 8 back-to-back beats alternating the round-1 and round-10 vectors.
    for (int k = 0; k < 10; k++) begin
      if (k < 8) begin
        in_valid = 1'b1;
        in_id    = ID_W'(k);
        in_last  = (k % 2 == 1);
        in_data  = (k % 2 == 1) ? R10_IN : R1_IN;
        in_rkey  = (k % 2 == 1) ? R10_KEY : R1_KEY;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      `CHK("stream_in_ready", in_ready, 1'b1)
      tick();
      if (k >= 1 && k <= 8) begin
        `CHK("stream_valid", out_valid, 1'b1)
        `CHK("stream_id", out_id, ID_W'(k - 1))
        `CHK("stream_data", out_data, ((k - 1) % 2 == 1) ? R10_OUT : R1_OUT)
      end else if (k == 9) begin
        `CHK("stream_end", out_valid, 1'b0)
      end
    end

    // Backpressure: out_ready low for 5 cycles while in_valid stays high.
    out_ready = 1'b0;
    nb = 0;
    in_valid = 1'b1;
    drive_rand(8);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      tick();
      if (acc) begin
        nb++;
        drive_rand(8 + nb);
      end
    end
    `CHK("bp_accepted", nb, 2)
    `CHK("bp_inflight", inflight, 2'd2)
    `CHK("bp_in_ready", in_ready, 1'b0)
    out_ready = 1'b1;
    #1;
    `CHK("bp_ready_rise", in_ready, 1'b1)
    tick();
    in_valid = 1'b0;
    `CHK("bp_accept_emit", inflight, 2'd2)
    drain("bp_drain");

    // Random valid/ready traffic.
    sent = 0;
    cyc  = 0;
    while (sent < 1000 && cyc < 20000) begin
      in_valid  = ($urandom_range(0, 9) >= 3);
      out_ready = ($urandom_range(0, 9) >= 3);
      drive_rand(int'($urandom_range(0, 15)));
      @(negedge clk);
      if (in_valid && in_ready) sent++;
      tick();
      cyc++;
    end
    `CHK("rand_sent", sent, 1000)
    drain("rand_drain");

    // Reset mid-stream with two beats held.
    out_ready = 1'b0;
    in_valid = 1'b1;
    drive_rand(1);
    tick();
    drive_rand(2);
    tick();
    in_valid = 1'b0;
    `CHK("mrst_full", inflight, 2'd2)
    #2;
    rst_n = 1'b0;
    #1;
    `CHK("mrst_out_valid", out_valid, 1'b0)
    `CHK("mrst_inflight", inflight, 2'd0)
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    out_ready = 1'b1;
    in_valid = 1'b1; in_last = 1'b1; in_data = R10_IN; in_rkey = R10_KEY; in_id = 4'd2;
    #1;
    `CHK("mrst_in_ready", in_ready, 1'b1)
    `CHK("mrst_no_stale", out_valid, 1'b0)
    tick();
    in_valid = 1'b0;
    `CHK("mrst_not_early", out_valid, 1'b0)
    tick();
    `CHK("mrst_valid", out_valid, 1'b1)
    `CHK("mrst_data", out_data, R10_OUT)
    `CHK("mrst_id", out_id, 4'd2)
    drain("mrst_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
